track_overlay_sched: RTL and testbench



---
 rtl/tracking_pkg.sv | 24 ++
 rtl/track_overlay_sched_if.sv | 23 ++
 rtl/frame_end_det.sv | 25 ++
 rtl/track_overlay_sched.sv | 136 +++++++++++++
 tb/tb_track_overlay_sched.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/tracking_pkg.sv
// Shared constants, state encoding and rounding helper for the tracking overlay path.
package tracking_pkg;

  localparam int FRAME_H = 640;
  localparam int FRAME_V = 480;
  localparam int SUB_H   = 64;
  localparam int SUB_V   = 48;

  localparam logic [9:0] OFFSCREEN = 10'h3FF;

  typedef enum logic [1:0] {
    NO_TRACK = 2'd0,
    TRACKING = 2'd1,
    COAST    = 2'd2
  } trk_state_t;

  // Rounded midpoint, kept in 11 bits so the carry is not lost.
  function automatic logic [9:0] avg_round(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b} + 11'd1;
    return s[10:1];
  endfunction

endpackage

// File: rtl/track_overlay_sched_if.sv
// Tracker-result handshake and committed overlay point between tracker, scheduler and adder.
interface track_overlay_sched_if;

  logic [9:0] i_trkH;
  logic [9:0] i_trkV;
  logic       i_trkVAL;
  logic       o_trkRDY;
  logic [9:0] o_pointH;
  logic [9:0] o_pointV;
  logic       o_pointVAL;
  logic       o_locked;

  modport master (
    output i_trkH, i_trkV, i_trkVAL,
    input  o_trkRDY, o_pointH, o_pointV, o_pointVAL, o_locked
  );

  modport slave (
    input  i_trkH, i_trkV, i_trkVAL,
    output o_trkRDY, o_pointH, o_pointV, o_pointVAL, o_locked
  );

endinterface

// File: rtl/frame_end_det.sv
// Registered one-cycle pulse following the last active pixel of a frame.
module frame_end_det #(
  parameter int FRAME_H = 640,
  parameter int FRAME_V = 480
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_h,
  input  logic [9:0] i_v,
  input  logic       i_rendering,
  output logic       o_fe
);

  localparam logic [9:0] LAST_H = 10'(FRAME_H - 1);
  localparam logic [9:0] LAST_V = 10'(FRAME_V - 1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fe <= 1'b0;
    end else begin
      o_fe <= i_rendering && (i_h == LAST_H) && (i_v == LAST_V);
    end
  end

endmodule

// File: rtl/track_overlay_sched.sv
// Holds the latest tracker result and commits it to the overlay point at frame end.
// Optional macro TRACK_SMOOTH_EN averages each tracked commit with the previous point.
//
// state    | meaning
// NO_TRACK | box off-screen, waiting for a result
// TRACKING | last frame end committed a fresh result
// COAST    | holding last point, counting missed frames toward retirement
module track_overlay_sched
  import tracking_pkg::*;
#(
  parameter int FRAME_H        = tracking_pkg::FRAME_H,
  parameter int FRAME_V        = tracking_pkg::FRAME_V,
  parameter int SUB_H          = tracking_pkg::SUB_H,
  parameter int SUB_V          = tracking_pkg::SUB_V,
  parameter int TIMEOUT_FRAMES = 8   // 1..255
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [9:0]           i_h,
  input  logic [9:0]           i_v,
  input  logic                 i_rendering,
  track_overlay_sched_if.slave bus
);

  localparam logic [9:0] H_MAX   = 10'(FRAME_H - 1 - SUB_H);
  localparam logic [9:0] V_MAX   = 10'(FRAME_V - 1 - SUB_V);
  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_FRAMES);

  trk_state_t state_q, state_d;
  logic [7:0] miss_q, miss_d, miss_nx;
  logic [9:0] pend_h_q, pend_v_q;
  logic       pend_flag_q, pend_flag_d;
  logic [9:0] point_h_q, point_h_d, point_v_q, point_v_d;
  logic       point_val_q, point_val_d;
  logic       rdy_q;
  logic       fe;
  logic       accept;
  logic [9:0] trk_h_cl, trk_v_cl;

  frame_end_det #(
    .FRAME_H (FRAME_H),
    .FRAME_V (FRAME_V)
  ) u_fe (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_h         (i_h),
    .i_v         (i_v),
    .i_rendering (i_rendering),
    .o_fe        (fe)
  );

  assign accept   = bus.i_trkVAL && rdy_q;
  assign trk_h_cl = (bus.i_trkH > H_MAX) ? H_MAX : bus.i_trkH;
  assign trk_v_cl = (bus.i_trkV > V_MAX) ? V_MAX : bus.i_trkV;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= NO_TRACK;
      miss_q      <= 8'd0;
      pend_h_q    <= 10'd0;
      pend_v_q    <= 10'd0;
      pend_flag_q <= 1'b0;
      point_h_q   <= OFFSCREEN;
      point_v_q   <= OFFSCREEN;
      point_val_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_q      <= miss_d;
      pend_flag_q <= pend_flag_d;
      point_h_q   <= point_h_d;
      point_v_q   <= point_v_d;
      point_val_q <= point_val_d;
      rdy_q       <= 1'b1;
      if (accept) begin
        pend_h_q <= trk_h_cl;
        pend_v_q <= trk_v_cl;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_d      = miss_q;
    miss_nx     = miss_q;
    pend_flag_d = pend_flag_q;
    point_h_d   = point_h_q;
    point_v_d   = point_v_q;
    point_val_d = 1'b0;

    if (fe) begin
      if (pend_flag_q) begin
`ifdef TRACK_SMOOTH_EN
        if (state_q != NO_TRACK) begin
          point_h_d = avg_round(point_h_q, pend_h_q);
          point_v_d = avg_round(point_v_q, pend_v_q);
        end else begin
          point_h_d = pend_h_q;
          point_v_d = pend_v_q;
        end
`else
        point_h_d = pend_h_q;
        point_v_d = pend_v_q;
`endif
        point_val_d = 1'b1;
        pend_flag_d = 1'b0;
        miss_d      = 8'd0;
        state_d     = TRACKING;
      end else if (state_q != NO_TRACK) begin
        miss_nx = (state_q == TRACKING) ? 8'd1 : miss_q + 8'd1;
        if (miss_nx == TIMEOUT) begin
          point_h_d   = OFFSCREEN;
          point_v_d   = OFFSCREEN;
          point_val_d = 1'b1;
          miss_d      = 8'd0;
          state_d     = NO_TRACK;
        end else begin
          miss_d  = miss_nx;
          state_d = COAST;
        end
      end
    end

    // A result accepted on the fe cycle is pending for the next frame.
    if (accept) begin
      pend_flag_d = 1'b1;
    end
  end

  assign bus.o_trkRDY   = rdy_q;
  assign bus.o_pointH   = point_h_q;
  assign bus.o_pointV   = point_v_q;
  assign bus.o_pointVAL = point_val_q;
  assign bus.o_locked   = (state_q == TRACKING) || (state_q == COAST);

endmodule

// File: tb/tb_track_overlay_sched.sv
// Directed bench for track_overlay_sched; frame ends are produced by driving the last pixel directly.
module tb_track_overlay_sched;

  localparam bit SMOOTH =
`ifdef TRACK_SMOOTH_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [9:0] h;
  logic [9:0] v;
  logic       rend;
  int         checks;
  int         errors;
  logic [9:0] eh;
  logic [9:0] ev;

  track_overlay_sched_if tif ();

  track_overlay_sched #(
    .TIMEOUT_FRAMES (3)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_h         (h),
    .i_v         (v),
    .i_rendering (rend),
    .bus         (tif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [9:0] sm(input logic [9:0] o, input logic [9:0] n);
    logic [10:0] s;
    s = {1'b0, o} + {1'b0, n} + 11'd1;
    return SMOOTH ? s[10:1] : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [9:0] th, input logic [9:0] tv);
    h = 10'd320;
    v = 10'd100;
    rend = 1'b1;
    tif.i_trkH = th;
    tif.i_trkV = tv;
    tif.i_trkVAL = 1'b1;
    @(negedge clk);
    tif.i_trkVAL = 1'b0;
  endtask

  // Last active pixel, then the fe cycle, then the commit edge; optional accept on the fe cycle.
  task automatic frame_end(input string tag, input logic exp_val, input logic [9:0] xh,
                           input logic [9:0] xv, input logic xlock, input logic acc,
                           input logic [9:0] ah, input logic [9:0] av);
    h = 10'd639;
    v = 10'd479;
    rend = 1'b1;
    @(negedge clk);
    h = 10'd0;
    v = 10'd0;
    rend = 1'b0;
    chk({tag, "_fe_cycle_val"}, 32'(tif.o_pointVAL), 32'd0);
    tif.i_trkH = ah;
    tif.i_trkV = av;
    tif.i_trkVAL = acc;
    @(negedge clk);
    tif.i_trkVAL = 1'b0;
    chk({tag, "_val"}, 32'(tif.o_pointVAL), 32'(exp_val));
    chk({tag, "_h"}, 32'(tif.o_pointH), 32'(xh));
    chk({tag, "_v"}, 32'(tif.o_pointV), 32'(xv));
    chk({tag, "_locked"}, 32'(tif.o_locked), 32'(xlock));
    @(negedge clk);
    chk({tag, "_val_width"}, 32'(tif.o_pointVAL), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    h = 10'd0;
    v = 10'd0;
    rend = 1'b0;
    tif.i_trkH = 10'd0;
    tif.i_trkV = 10'd0;
    tif.i_trkVAL = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_h", 32'(tif.o_pointH), 32'h3FF);
    chk("rst_v", 32'(tif.o_pointV), 32'h3FF);
    chk("rst_val", 32'(tif.o_pointVAL), 32'd0);
    chk("rst_rdy", 32'(tif.o_trkRDY), 32'd0);
    chk("rst_locked", 32'(tif.o_locked), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(tif.o_trkRDY), 32'd1);

    // First result from NO_TRACK is committed unsmoothed
    send(10'd100, 10'd200);
    frame_end("t1", 1'b1, 10'd100, 10'd200, 1'b1, 1'b0, 10'd0, 10'd0);
    eh = 10'd100;
    ev = 10'd200;

    // Clamping and latest-wins
    send(10'd600, 10'd470);
    send(10'd610, 10'd300);
    eh = sm(eh, 10'd575);
    ev = sm(ev, 10'd300);
    frame_end("t2", 1'b1, eh, ev, 1'b1, 1'b0, 10'd0, 10'd0);
    frame_end("t2_coast", 1'b0, eh, ev, 1'b1, 1'b0, 10'd0, 10'd0);

    // Accept on the fe cycle while (10,20) is pending
    send(10'd10, 10'd20);
    eh = sm(eh, 10'd10);
    ev = sm(ev, 10'd20);
    frame_end("t3a", 1'b1, eh, ev, 1'b1, 1'b1, 10'd50, 10'd60);
    eh = sm(eh, 10'd50);
    ev = sm(ev, 10'd60);
    frame_end("t3b", 1'b1, eh, ev, 1'b1, 1'b0, 10'd0, 10'd0);

    // Timeout after 3 missed frames
    frame_end("t4_miss1", 1'b0, eh, ev, 1'b1, 1'b0, 10'd0, 10'd0);
    frame_end("t4_miss2", 1'b0, eh, ev, 1'b1, 1'b0, 10'd0, 10'd0);
    frame_end("t4_retire", 1'b1, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 10'd0, 10'd0);
    frame_end("t4_idle", 1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 10'd0, 10'd0);

    // Smoothing on a tracked commit
    send(10'd100, 10'd100);
    frame_end("t5a", 1'b1, 10'd100, 10'd100, 1'b1, 1'b0, 10'd0, 10'd0);
    send(10'd201, 10'd50);
    frame_end("t5b", 1'b1, SMOOTH ? 10'd151 : 10'd201, SMOOTH ? 10'd75 : 10'd50, 1'b1,
              1'b0, 10'd0, 10'd0);

    // Asynchronous reset with a result pending
    send(10'd300, 10'd300);
    h = 10'd320;
    v = 10'd240;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_h", 32'(tif.o_pointH), 32'h3FF);
    chk("t6_v", 32'(tif.o_pointV), 32'h3FF);
    chk("t6_rdy", 32'(tif.o_trkRDY), 32'd0);
    chk("t6_locked", 32'(tif.o_locked), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_end("t6_fe", 1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 10'd0, 10'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
